// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: Funct3 access encodings,
// FSM state type and access-size decoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } lsu_size_t;

    // Unlisted encodings (011, 110, 111) fall through to word accesses.
    function automatic lsu_size_t f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

    function automatic logic f3_unsigned(input logic [2:0] f3);
        return (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, store-data replication, load
// extraction/extension and misalign detection (active with LSU_MISALIGN_TRAP_EN).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  f3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_o,
    output logic        misalign_o
);

    lsu_size_t   size;
    logic        unsigned_ld;
    logic [1:0]  aoff;
    logic [31:0] shifted;

    always_comb begin
        size        = f3_size(f3_i);
        unsigned_ld = f3_unsigned(f3_i);
        aoff        = 2'b00;
        be_o        = 4'b1111;
        wdata_o     = wdata_i;
        // Offset bits that would misalign the access are dropped here.
        case (size)
            SZ_BYTE: begin
                aoff    = off_i;
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                aoff    = {off_i[1], 1'b0};
                be_o    = 4'b0011 << aoff;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase

        shifted = rdata_i >> {aoff, 3'b000};
        case (size)
            SZ_BYTE: load_o = unsigned_ld ? {24'h0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_o = unsigned_ld ? {16'h0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: load_o = shifted;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_o = ((size == SZ_HALF) && off_i[0]) ||
                        ((size == SZ_WORD) && (off_i != 2'b00));
`else
    assign misalign_o = 1'b0;
`endif

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit bridging the datapath to a req/ack data bus.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MisalignErr,
    output logic        BusReq,
    output logic        BusWe,
    output logic [31:0] BusAddr,
    output logic [3:0]  BusBe,
    output logic [31:0] BusWdata,
    input  logic        BusAck,
    input  logic [31:0] BusRdata
);

    lsu_state_t  state_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        we_q;
    logic        req_q;
    logic        misalign_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [3:0]  be_q;

    logic        access_w;
    logic [2:0]  f3_sel;
    logic [1:0]  off_sel;
    logic [3:0]  be_w;
    logic [31:0] wdata_w;
    logic [31:0] load_w;
    logic        misalign_w;

    assign access_w = MemRead | MemWrite;

    // The aligner sees live inputs in IDLE (to latch lanes and decide on a trap)
    // and the latched request afterwards (to extract load data on ack).
    assign f3_sel  = (state_q == IDLE) ? Funct3    : f3_q;
    assign off_sel = (state_q == IDLE) ? Addr[1:0] : off_q;

    lsu_align u_align (
        .f3_i       (f3_sel),
        .off_i      (off_sel),
        .wdata_i    (WriteData),
        .rdata_i    (BusRdata),
        .be_o       (be_w),
        .wdata_o    (wdata_w),
        .load_o     (load_w),
        .misalign_o (misalign_w)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            f3_q       <= '0;
            off_q      <= '0;
            we_q       <= 1'b0;
            req_q      <= 1'b0;
            misalign_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            be_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (access_w) begin
                        f3_q  <= Funct3;
                        off_q <= Addr[1:0];
                        if (misalign_w) begin
                            state_q    <= DONE;
                            misalign_q <= 1'b1;
                            if (!MemWrite) begin
                                rdata_q <= '0;
                            end
                        end else begin
                            state_q <= BUSY;
                            req_q   <= 1'b1;
                            we_q    <= MemWrite;
                            addr_q  <= {Addr[31:2], 2'b00};
                            be_q    <= be_w;
                            wdata_q <= wdata_w;
                        end
                    end
                end
                BUSY: begin
                    if (BusAck) begin
                        state_q <= DONE;
                        req_q   <= 1'b0;
                        if (!we_q) begin
                            rdata_q <= load_w;
                        end
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    misalign_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Stall       = (state_q == BUSY) || ((state_q == IDLE) && reset && access_w);
    assign ReadData    = rdata_q;
    assign MisalignErr = misalign_q;
    assign BusReq      = req_q;
    assign BusWe       = we_q;
    assign BusAddr     = addr_q;
    assign BusBe       = be_q;
    assign BusWdata    = wdata_q;

endmodule
